mips_stage_controller: RTL

Multi-cycle sequencer for the single-issue MIPS datapath. It walks each instruction through FETCH → DECODE → EXECUTE → [MEMORY] → [WRITEBACK] and drives the datapath control inputs: ce, RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite and MemtoReg. It also enforces a memory ready handshake with timeout, stops on illegal opcodes, and counts retired instructions. It sits beside `datapath`, consuming the decoded opcode and the ALU zero flag.

---
 rtl/mips_stage_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mips_stage_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the MIPS datapath.
// Controls decode from the state and latched opcode registers only; no input reaches an output combinationally.
module mips_stage_controller #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH    = 32,
  parameter int MEM_TIMEOUT  = 15,
  parameter int TO_WIDTH     = 4
) (
  input  logic                    c_clk,
  input  logic                    c_rst,
  input  logic                    c_i_start,
  input  logic                    c_i_stop,
  input  logic                    c_i_clear,
  input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
  input  logic                    c_i_zero,
  input  logic                    c_i_mem_ready,
  output logic                    c_o_ce,
  output logic                    c_o_reg_dst,
  output logic                    c_o_reg_write,
  output logic                    c_o_alu_src,
  output logic                    c_o_branch,
  output logic                    c_o_mem_read,
  output logic                    c_o_mem_write,
  output logic                    c_o_mem_to_reg,
  output logic [2:0]              c_o_state,
  output logic                    c_o_busy,
  output logic                    c_o_illegal,
  output logic                    c_o_timeout,
  output logic [CNT_WIDTH-1:0]    c_o_retired
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
  localparam logic [TO_WIDTH-1:0]     TO_LAST = TO_WIDTH'(MEM_TIMEOUT - 1);

  state_t                  state;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [TO_WIDTH-1:0]     to_cnt;
  logic [CNT_WIDTH-1:0]    retired;
  logic                    illegal;
  logic                    timeout;

  // Zero flag is informational only; branch resolution lives in the datapath.
  logic unused_zero;
  assign unused_zero = c_i_zero;

  function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ);
  endfunction

  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      state    <= IDLE;
      opcode_q <= '0;
      to_cnt   <= '0;
      retired  <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (c_i_start) state <= FETCH;
        FETCH: state <= DECODE;
        DECODE: begin
          opcode_q <= c_i_opcode;
          if (is_legal(c_i_opcode)) begin
            state <= EXECUTE;
          end else begin
            state   <= HALT;
            illegal <= 1'b1;
          end
        end
        EXECUTE: begin
          if (opcode_q == OP_BEQ) begin
            retired <= retired + 1'b1;
            state   <= c_i_stop ? IDLE : FETCH;
          end else if (opcode_q == OP_LW || opcode_q == OP_SW) begin
            state  <= MEMORY;
            to_cnt <= '0;
          end else begin
            state <= WRITEBACK;
          end
        end
        MEMORY: begin
          // Ready takes priority over an expiring timeout in the same cycle.
          if (c_i_mem_ready) begin
            if (opcode_q == OP_LW) begin
              state <= WRITEBACK;
            end else begin
              retired <= retired + 1'b1;
              state   <= c_i_stop ? IDLE : FETCH;
            end
          end else if (to_cnt == TO_LAST) begin
            state   <= HALT;
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WRITEBACK: begin
          retired <= retired + 1'b1;
          state   <= c_i_stop ? IDLE : FETCH;
        end
        HALT: begin
          if (c_i_clear) begin
            state   <= IDLE;
            illegal <= 1'b0;
            timeout <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    c_o_ce         = 1'b0;
    c_o_reg_dst    = 1'b0;
    c_o_reg_write  = 1'b0;
    c_o_alu_src    = 1'b0;
    c_o_branch     = 1'b0;
    c_o_mem_read   = 1'b0;
    c_o_mem_write  = 1'b0;
    c_o_mem_to_reg = 1'b0;
    unique case (state)
      FETCH, DECODE: c_o_ce = 1'b1;
      EXECUTE: begin
        c_o_ce      = 1'b1;
        c_o_alu_src = (opcode_q == OP_ADDI) || (opcode_q == OP_LW) || (opcode_q == OP_SW);
        c_o_branch  = (opcode_q == OP_BEQ);
      end
      MEMORY: begin
        c_o_ce        = 1'b1;
        c_o_mem_read  = (opcode_q == OP_LW);
        c_o_mem_write = (opcode_q == OP_SW);
      end
      WRITEBACK: begin
        c_o_ce         = 1'b1;
        c_o_reg_write  = 1'b1;
        c_o_reg_dst    = (opcode_q == OP_R);
        c_o_mem_to_reg = (opcode_q == OP_LW);
      end
      default: ;
    endcase
  end

  assign c_o_state   = state;
  assign c_o_busy    = (state != IDLE) && (state != HALT);
  assign c_o_illegal = illegal;
  assign c_o_timeout = timeout;
  assign c_o_retired = retired;

endmodule
